traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Cycle controller for the two-road (main/sub) traffic light. Divides the system clock to a 1 Hz tick, sequences both roads through green/yellow/red with per-road countdowns, and handles pause and flashing ("online") modes. It drives the light state, color code, remaining time and BCD display words that the power-on initial values describe, taking over from them after reset.

## Interface

- CLOCK_HZ, 5: clock cycles per 1 s tick (≥2)
- REDT, 19: red duration in ticks (must equal GREENT+YELLOWT)
- GREENT, 16: green duration in ticks
- YELLOWT, 3: yellow duration in ticks
- Color codes: REDL=1, GREENL=2, YELLOWL=3, ONLINEL=4
- State codes: REDS=0, GREENS=1, YELLOWS=2, ONLINES=3, PAUSES=4

Ports:

- clk  in  1  system clock; the block has a single clock domain
- rst_n  in  1  asynchronous, active-low reset
- pause  in  1  level; freezes sequencing while high
- online  in  1  level; flashing mode while high; takes priority over pause
- Source  out  1  lamp power enable (blink in online mode)
- MainTime, SubTime  out  16  BCD display {8'h00, tens, ones} of rest time
- MainColor, SubColor  out  8  color code, zero-extended
- main_light_state, sub_light_state  out  3  state code
- main_rest_time, sub_reset_time  out  5  remaining ticks, binary

## Operation

- All outputs are registered.
- Reset values (async, rst_n low):
  - Source=1, MainTime=16'h0016, SubTime=16'h0019
  - MainColor=GREENL, SubColor=REDL
  - main_light_state=GREENS, sub_light_state=REDS
  - main_rest_time=16, sub_reset_time=19
  - phase=P0, prescaler=0
- Prescaler counts 0..CLOCK_HZ-1 and wraps. tick=1 when count==CLOCK_HZ-1 and the block is not frozen.
- Phases (main/sub):
  - P0 GREEN/RED
  - P1 YELLOW/RED
  - P2 RED/GREEN
  - P3 RED/YELLOW
  - P3 returns to P0.
- Countdown: on each tick, each road's rest time decrements by 1.
- A road whose rest time is 1 at a tick instead reloads the duration of its next color and changes color and state. Green moves to yellow (YELLOWT), yellow to red (REDT), red to green (GREENT).
- The red timer runs continuously across two phases. Main and sub transitions therefore coincide: P0→P1 main only, P1→P2 both, P2→P3 sub only, P3→P0 both.
- Rest time never shows 0 in normal mode. The range is 1..REDT.
- Display: tens = rest≥10 ? 1 : 0 (2 if ≥20), ones = rest − 10·tens. Upper byte is always 0.
- Pause (online low):
  - Prescaler, phase and timers hold; colors and times hold.
  - Both light_state outputs read PAUSES.
- On pause release, the light_state outputs restore GREENS/YELLOWS/REDS from the held phase, and counting resumes from the held prescaler value.
- Online (highest priority):
  - Both colors = ONLINEL, both states = ONLINES.
  - Rest times = 0, display words = 16'h0000.
  - Prescaler is cleared on entry, then runs; Source toggles on every tick, starting at 1.
- Online exit: on the first cycle with online low, force the full reset values (P0, prescaler 0, Source=1).
- If pause is high at online exit, the state outputs read PAUSES from the next cycle.

## Timing

- Inputs are sampled on the rising edge of clk. Effects are visible on the following edge (one-cycle latency).
- With CLOCK_HZ=5, the first decrement (main 15, sub 18) appears on the 5th rising edge after rst_n deasserts.
- Phase lengths: P0 = GREENT·CLOCK_HZ = 80 cycles, P1 = 15 cycles. A full cycle is 190 cycles.
- Pause edges:
  - Pause high on the edge where prescaler==CLOCK_HZ-1: no tick occurs.
  - Pause low for one cycle: the prescaler advances exactly once.
- Online while paused: online wins immediately. Pause is ignored until online drops.
- Reset mid-phase or mid-online returns to the reset values asynchronously.

## Test plan

- Reset release, run 190 cycles:
  - Main goes 16→1 green, 3→1 yellow, 19→1 red.
  - Sub goes 19→1 red, 16→1 green, 3→1 yellow.
  - Back to P0 at cycle 190 with MainTime=16'h0016.
- BCD check: rest times 19, 10, 9, 1 show 16'h0019, 16'h0010, 16'h0009, 16'h0001.
- Pause asserted at main_rest_time=7, prescaler=2, held 23 cycles:
  - States read PAUSES and times frozen.
  - After release, main shows 6 exactly 3 cycles later.
- Online asserted in P2:
  - States ONLINES, colors 4, times 0.
  - Source toggles every 5 cycles.
  - On release, all outputs equal the reset values one cycle later.
- Online and pause both high, then online drops:
  - ONLINES first, then PAUSES with P0 values.
- rst_n pulsed low mid-P1 for 1 cycle: outputs are immediately the reset values, and the next decrement follows 5 cycles after release.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Two-road (main/sub) traffic light cycle controller.
// A prescaler divides clk down to a 1 s tick. Both roads step through
// green/yellow/red with per-road countdowns. Pause freezes sequencing.
// Online (flashing) mode blanks the timers and blinks Source.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   pause            level, freezes sequencing while high
//   online           level, flashing mode while high (overrides pause)
//   Source           lamp power enable, blinks in online mode
//   MainTime/SubTime BCD rest time {8'h00, tens, ones}
//   MainColor/SubColor            color code
//   main_light_state/sub_light_state  state code
//   main_rest_time/sub_reset_time     remaining ticks, binary
module traffic_light_ctrl #(
  parameter int CLOCK_HZ = 5,
  parameter int REDT     = 19,
  parameter int GREENT   = 16,
  parameter int YELLOWT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pause,
  input  logic        online,
  output logic        Source,
  output logic [15:0] MainTime,
  output logic [15:0] SubTime,
  output logic [7:0]  MainColor,
  output logic [7:0]  SubColor,
  output logic [2:0]  main_light_state,
  output logic [2:0]  sub_light_state,
  output logic [4:0]  main_rest_time,
  output logic [4:0]  sub_reset_time
);

  localparam logic [7:0] REDL    = 8'd1;
  localparam logic [7:0] GREENL  = 8'd2;
  localparam logic [7:0] YELLOWL = 8'd3;
  localparam logic [7:0] ONLINEL = 8'd4;
  localparam int CW = $clog2(CLOCK_HZ);

  typedef enum logic [2:0] {
    REDS    = 3'd0,
    GREENS  = 3'd1,
    YELLOWS = 3'd2,
    ONLINES = 3'd3,
    PAUSES  = 3'd4
  } lstate_t;

  // Phases named main/sub: P0 G/R, P1 Y/R, P2 R/G, P3 R/Y
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  logic [CW-1:0] cnt_q, cnt_n;
  phase_t        phase_q, phase_n;
  logic          online_q;
  lstate_t       mst_q, mst_n, sst_q, sst_n;
  logic          source_n;
  logic [15:0]   mtime_n, stime_n;
  logic [7:0]    mcolor_n, scolor_n;
  logic [4:0]    mrest_n, srest_n;
  logic          last;

  assign main_light_state = mst_q;
  assign sub_light_state  = sst_q;
  assign last = (cnt_q == CW'(CLOCK_HZ - 1));

  function automatic logic [15:0] bcd(input logic [4:0] r);
    logic [3:0] tens;
    logic [4:0] ones;
    if (r >= 5'd20) begin
      tens = 4'd2;
      ones = r - 5'd20;
    end else if (r >= 5'd10) begin
      tens = 4'd1;
      ones = r - 5'd10;
    end else begin
      tens = 4'd0;
      ones = r;
    end
    return {8'h00, tens, ones[3:0]};
  endfunction

  function automatic lstate_t main_state(input phase_t p);
    case (p)
      P0:      return GREENS;
      P1:      return YELLOWS;
      default: return REDS;
    endcase
  endfunction

  function automatic lstate_t sub_state(input phase_t p);
    case (p)
      P2:      return GREENS;
      P3:      return YELLOWS;
      default: return REDS;
    endcase
  endfunction

  function automatic logic [7:0] color_of(input lstate_t s);
    case (s)
      GREENS:  return GREENL;
      YELLOWS: return YELLOWL;
      default: return REDL;
    endcase
  endfunction

  always_comb begin
    cnt_n    = cnt_q;
    phase_n  = phase_q;
    mst_n    = mst_q;
    sst_n    = sst_q;
    source_n = Source;
    mtime_n  = MainTime;
    stime_n  = SubTime;
    mcolor_n = MainColor;
    scolor_n = SubColor;
    mrest_n  = main_rest_time;
    srest_n  = sub_reset_time;

    if (online) begin
      if (!online_q) begin
        cnt_n    = '0;
        source_n = 1'b1;
      end else begin
        cnt_n = last ? '0 : cnt_q + 1'b1;
        if (last) source_n = ~Source;
      end
      mst_n    = ONLINES;
      sst_n    = ONLINES;
      mcolor_n = ONLINEL;
      scolor_n = ONLINEL;
      mrest_n  = '0;
      srest_n  = '0;
      mtime_n  = '0;
      stime_n  = '0;
    end else if (online_q) begin
      // First cycle out of online mode: restart from the power-on picture.
      cnt_n    = '0;
      phase_n  = P0;
      source_n = 1'b1;
      mst_n    = GREENS;
      sst_n    = REDS;
      mcolor_n = GREENL;
      scolor_n = REDL;
      mrest_n  = 5'(GREENT);
      srest_n  = 5'(REDT);
      mtime_n  = bcd(5'(GREENT));
      stime_n  = bcd(5'(REDT));
    end else if (pause) begin
      mst_n = PAUSES;
      sst_n = PAUSES;
    end else begin
      cnt_n = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        if (main_rest_time == 5'd1) begin
          case (phase_q)
            P0:      mrest_n = 5'(YELLOWT);
            P1:      mrest_n = 5'(REDT);
            default: mrest_n = 5'(GREENT);
          endcase
        end else begin
          mrest_n = main_rest_time - 5'd1;
        end
        if (sub_reset_time == 5'd1) begin
          case (phase_q)
            P2:      srest_n = 5'(YELLOWT);
            P3:      srest_n = 5'(REDT);
            default: srest_n = 5'(GREENT);
          endcase
        end else begin
          srest_n = sub_reset_time - 5'd1;
        end
        // P1->P2 and P3->P0 are driven by both roads expiring together.
        case (phase_q)
          P0: if (main_rest_time == 5'd1) phase_n = P1;
          P1: if (main_rest_time == 5'd1) phase_n = P2;
          P2: if (sub_reset_time == 5'd1) phase_n = P3;
          P3: if (sub_reset_time == 5'd1) phase_n = P0;
          default: phase_n = P0;
        endcase
      end
      mst_n    = main_state(phase_n);
      sst_n    = sub_state(phase_n);
      mcolor_n = color_of(main_state(phase_n));
      scolor_n = color_of(sub_state(phase_n));
      mtime_n  = bcd(mrest_n);
      stime_n  = bcd(srest_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      phase_q        <= P0;
      online_q       <= 1'b0;
      mst_q          <= GREENS;
      sst_q          <= REDS;
      Source         <= 1'b1;
      MainTime       <= 16'h0016;
      SubTime        <= 16'h0019;
      MainColor      <= GREENL;
      SubColor       <= REDL;
      main_rest_time <= 5'(GREENT);
      sub_reset_time <= 5'(REDT);
    end else begin
      cnt_q          <= cnt_n;
      phase_q        <= phase_n;
      online_q       <= online;
      mst_q          <= mst_n;
      sst_q          <= sst_n;
      Source         <= source_n;
      MainTime       <= mtime_n;
      SubTime        <= stime_n;
      MainColor      <= mcolor_n;
      SubColor       <= scolor_n;
      main_rest_time <= mrest_n;
      sub_reset_time <= srest_n;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl
// Directed bench for traffic_light_ctrl with default parameters
// (CLOCK_HZ=5, REDT=19, GREENT=16, YELLOWT=3). cyc counts rising edges
// since rst_n release; expected values are hand-computed per cycle.
module tb_traffic_light_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pause = 1'b0;
  logic        online = 1'b0;
  logic        Source;
  logic [15:0] MainTime, SubTime;
  logic [7:0]  MainColor, SubColor;
  logic [2:0]  main_light_state, sub_light_state;
  logic [4:0]  main_rest_time, sub_reset_time;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  traffic_light_ctrl #(
    .CLOCK_HZ(5),
    .REDT(19),
    .GREENT(16),
    .YELLOWT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pause(pause),
    .online(online),
    .Source(Source),
    .MainTime(MainTime),
    .SubTime(SubTime),
    .MainColor(MainColor),
    .SubColor(SubColor),
    .main_light_state(main_light_state),
    .sub_light_state(sub_light_state),
    .main_rest_time(main_rest_time),
    .sub_reset_time(sub_reset_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_src"},  32'(Source), 32'd1);
    check({tag, "_mt"},   32'(MainTime), 32'h0016);
    check({tag, "_st"},   32'(SubTime), 32'h0019);
    check({tag, "_mc"},   32'(MainColor), 32'd2);
    check({tag, "_sc"},   32'(SubColor), 32'd1);
    check({tag, "_mrt"},  32'(main_rest_time), 32'd16);
    check({tag, "_srt"},  32'(sub_reset_time), 32'd19);
  endtask

  task automatic check_road(input string tag, input int mr, input int sr,
                            input int mst, input int sst);
    check({tag, "_mrt"}, 32'(main_rest_time), 32'(mr));
    check({tag, "_srt"}, 32'(sub_reset_time), 32'(sr));
    check({tag, "_mst"}, 32'(main_light_state), 32'(mst));
    check({tag, "_sst"}, 32'(sub_light_state), 32'(sst));
  endtask

  initial begin
    // Reset state while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    check("rst_mst", 32'(main_light_state), 32'd1);
    check("rst_sst", 32'(sub_light_state), 32'd0);
    rst_n = 1'b1;

    // Normal cycle: tick k lands on cyc 5k
    run_to(4);
    check("pre_tick_mrt", 32'(main_rest_time), 32'd16);
    step();
    check_road("tick1", 15, 18, 1, 0);
    check("tick1_MainTime", 32'(MainTime), 32'h0015);
    run_to(75);  check_road("k15", 1, 4, 1, 0);
    run_to(80);  check_road("k16", 3, 3, 2, 0);
    check("k16_MainColor", 32'(MainColor), 32'd3);
    run_to(90);  check_road("k18", 1, 1, 2, 0);
    run_to(95);  check_road("k19", 19, 16, 0, 1);
    check("k19_MainTime", 32'(MainTime), 32'h0019);
    check("k19_SubColor", 32'(SubColor), 32'd2);
    run_to(140); check("k28_MainTime", 32'(MainTime), 32'h0010);
    run_to(145); check("k29_MainTime", 32'(MainTime), 32'h0009);
    run_to(170); check_road("k34", 4, 1, 0, 1);
    run_to(175); check_road("k35", 3, 3, 0, 2);
    run_to(185); check("k37_MainTime", 32'(MainTime), 32'h0001);
    run_to(189); check_road("k37_hold", 1, 1, 0, 2);
    run_to(190); check_road("k38", 16, 19, 1, 0);
    check("k38_MainTime", 32'(MainTime), 32'h0016);

    // Pause at main=7, prescaler=2, held for 23 edges (238..260)
    run_to(237);
    check("pre_pause_mrt", 32'(main_rest_time), 32'd7);
    pause = 1'b1;
    run_to(238); check_road("pause_in", 7, 10, 4, 4);
    check("pause_SubTime", 32'(SubTime), 32'h0010);
    run_to(260); check_road("pause_end", 7, 10, 4, 4);
    pause = 1'b0;
    run_to(261); check_road("unpause", 7, 10, 1, 0);
    run_to(262); check("unpause2_mrt", 32'(main_rest_time), 32'd7);
    run_to(263); check("unpause3_mrt", 32'(main_rest_time), 32'd6);
    check("unpause3_SubTime", 32'(SubTime), 32'h0009);

    // Online during P2 (tick k at cyc 5k+23; P2 spans k=57..72)
    run_to(310);
    check("pre_online_mst", 32'(main_light_state), 32'd0);
    check("pre_online_sst", 32'(sub_light_state), 32'd1);
    online = 1'b1;
    run_to(311);
    check_road("online", 0, 0, 3, 3);
    check("online_mc", 32'(MainColor), 32'd4);
    check("online_sc", 32'(SubColor), 32'd4);
    check("online_mt", 32'(MainTime), 32'h0000);
    check("online_st", 32'(SubTime), 32'h0000);
    check("online_src0", 32'(Source), 32'd1);
    run_to(315); check("online_src4", 32'(Source), 32'd1);
    run_to(316); check("online_src5", 32'(Source), 32'd0);
    run_to(320); check("online_src9", 32'(Source), 32'd0);
    run_to(321); check("online_src10", 32'(Source), 32'd1);
    online = 1'b0;
    run_to(322);
    check_reset_vals("online_exit");
    check("online_exit_mst", 32'(main_light_state), 32'd1);
    run_to(326); check("exit_hold_mrt", 32'(main_rest_time), 32'd16);
    run_to(327); check("exit_tick_mrt", 32'(main_rest_time), 32'd15);

    // Online and pause together, then online drops with pause still high
    online = 1'b1;
    pause = 1'b1;
    run_to(328); check_road("onpause", 0, 0, 3, 3);
    run_to(330); check("onpause_hold_mst", 32'(main_light_state), 32'd3);
    online = 1'b0;
    run_to(331); check_reset_vals("onpause_exit");
    run_to(332); check_road("onpause_paused", 16, 19, 4, 4);
    check("onpause_paused_mc", 32'(MainColor), 32'd2);
    pause = 1'b0;

    // Tick j at cyc 332+5j; j=16 (cyc 412) enters P1
    run_to(413); check_road("p1", 3, 3, 2, 0);
    run_to(414);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    check("async_rst_mst", 32'(main_light_state), 32'd1);
    step();
    rst_n = 1'b1;
    run_to(419); check("post_rst_hold_mrt", 32'(main_rest_time), 32'd16);
    run_to(420); check_road("post_rst_tick", 15, 18, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
